// File: rtl/xbtn_input_pkg.sv
// Shared definitions for the xbtn_input peripheral: register offsets seen by the
// address decoder.
package xbtn_input_pkg;

  localparam logic [1:0] XBTN_EVT = 2'd0;
  localparam logic [1:0] XBTN_SW  = 2'd1;
  localparam logic [1:0] XBTN_CLR = 2'd2;
  localparam logic [1:0] XBTN_CFG = 2'd3;

endpackage

// File: rtl/xbtn_input_xdebounce.sv
// Button debouncer: a level is accepted only after it has been stable for
// DEBOUNCE_CYCLES synced samples. Emits a one-cycle rise pulse on acceptance of a press.
//
//   state     | meaning
//   STABLE_LO | accepted level 0, input agrees
//   WAIT_HI   | input went high, counting stable high samples
//   STABLE_HI | accepted level 1, input agrees
//   WAIT_LO   | input went low, counting stable low samples
module xdebounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic din_sync,
  output logic level,
  output logic rise
);

  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_t;

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // The sample that moves the FSM into a WAIT state already counts as stable,
  // so the count to commit is one short of DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_level, w_level_nxt;
  logic             w_rise;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise      = 1'b0;
    case (r_state)
      STABLE_LO: begin
        if (din_sync) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!din_sync) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= CNT_LAST) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_rise      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!din_sync) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (din_sync) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= CNT_LAST) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_cnt_nxt   = '0;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  assign level = r_level;
  assign rise  = w_rise;

endmodule

// File: rtl/xbtn_input.sv
// Memory-mapped button/switch input block: synchronises pins, debounces buttons,
// holds sticky press and switch-change flags until the controller clears them.
module xbtn_input
  import xbtn_input_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int SW_W            = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn2,
  input  logic              btn3,
  input  logic [SW_W-1:0]   sw,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              irq_pend
);

  logic [1:0]      r_btn_s1, r_btn_s2;
  logic [SW_W-1:0] r_sw_s1, r_sw_q, r_sw_prev;
  logic            r_sw_chg;
  logic [1:0]      r_evt;
  logic            r_irq;

  logic [1:0]      w_lvl, w_rise, w_clr_evt;
  logic            w_rd, w_wr, w_clr_chg;
  logic            w_unused;

  xdebounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb2 (
    .clk(clk), .rst(rst), .din_sync(r_btn_s2[0]), .level(w_lvl[0]), .rise(w_rise[0])
  );

  xdebounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb3 (
    .clk(clk), .rst(rst), .din_sync(r_btn_s2[1]), .level(w_lvl[1]), .rise(w_rise[1])
  );

  assign w_rd      = sel & ~we;
  assign w_wr      = sel & we;
  assign w_clr_evt = {2{w_rd && (addr == XBTN_EVT)}}
                   | ({2{w_wr && (addr == XBTN_CLR)}} & data_in[1:0]);
  assign w_clr_chg = w_rd && (addr == XBTN_SW);
  assign w_unused  = &{1'b0, data_in[DATA_W-1:2]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_btn_s1  <= '0;
      r_btn_s2  <= '0;
      r_sw_s1   <= '0;
      r_sw_q    <= '0;
      r_sw_prev <= '0;
      r_sw_chg  <= 1'b0;
      r_evt     <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_btn_s1  <= {btn3, btn2};
      r_btn_s2  <= r_btn_s1;
      r_sw_s1   <= sw;
      r_sw_q    <= r_sw_s1;
      r_sw_prev <= r_sw_q;
      // Set wins over a clear landing in the same cycle.
      r_sw_chg  <= (r_sw_q != r_sw_prev) | (r_sw_chg & ~w_clr_chg);
      r_evt     <= w_rise | (r_evt & ~w_clr_evt);
      r_irq     <= |r_evt;
    end
  end

  always_comb begin
    data_out = '0;
    if (sel) begin
      case (addr)
        XBTN_EVT: data_out[3:0]    = {r_evt[1], r_evt[0], w_lvl[1], w_lvl[0]};
        XBTN_SW:  data_out[SW_W:0] = {r_sw_chg, r_sw_q};
        XBTN_CFG: data_out         = DATA_W'(DEBOUNCE_CYCLES);
        default:  data_out         = '0;
      endcase
    end
  end

  assign irq_pend = r_irq;

endmodule

// File: tb/tb_xbtn_input.sv
// Bench for xbtn_input: directed scenarios plus random pin/bus traffic, every cycle
// compared against a run-length behavioural model of the peripheral.
module tb_xbtn_input;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, btn2, btn3, sel, we, irq_pend;
  logic [7:0]  sw;
  logic [1:0]  addr;
  logic [31:0] data_in, data_out;

  always #5 clk = ~clk;

  xbtn_input #(.DATA_W(32), .SW_W(8), .DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst(rst), .btn2(btn2), .btn3(btn3), .sw(sw), .sel(sel), .we(we),
    .addr(addr), .data_in(data_in), .data_out(data_out), .irq_pend(irq_pend)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: pins delayed by two samples; a level flips once the synced input has
  // disagreed with it for N consecutive samples.
  logic [1:0] m_bs1, m_bs2, m_lvl, m_evt;
  int         m_run [2];
  logic [7:0] m_sw1, m_sw2, m_swp;
  logic       m_chg, m_irq;
  logic [31:0] obs;
  logic        obs_irq;

  function automatic logic [31:0] m_read();
    if (!sel) return 32'd0;
    case (addr)
      2'd0:    return {28'd0, m_evt[1], m_evt[0], m_lvl[1], m_lvl[0]};
      2'd1:    return {23'd0, m_chg, m_sw2};
      2'd2:    return 32'd0;
      default: return 32'(N);
    endcase
  endfunction

  task automatic m_step();
    logic [1:0] rise, clr;
    logic rd, wr;
    if (!rst) begin
      m_bs1 = '0; m_bs2 = '0; m_lvl = '0; m_evt = '0;
      m_run[0] = 0; m_run[1] = 0;
      m_sw1 = '0; m_sw2 = '0; m_swp = '0; m_chg = 1'b0; m_irq = 1'b0;
    end else begin
      rd  = sel && !we;
      wr  = sel && we;
      clr = 2'b00;
      if (rd && addr == 2'd0) clr = 2'b11;
      if (wr && addr == 2'd2) clr = clr | data_in[1:0];
      rise = 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (m_bs2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == N) begin
            rise[i]  = m_bs2[i];
            m_lvl[i] = m_bs2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_irq = |m_evt;
      m_evt = rise | (m_evt & ~clr);
      m_chg = (m_sw2 != m_swp) || (m_chg && !(rd && addr == 2'd1));
      m_swp = m_sw2;
      m_sw2 = m_sw1;
      m_sw1 = sw;
      m_bs2 = m_bs1;
      m_bs1 = {btn3, btn2};
    end
  endtask

  task automatic tick();
    @(negedge clk);
    obs     = data_out;
    obs_irq = irq_pend;
    chk("dout_model", data_out, m_read());
    chk("irq_model", {31'd0, irq_pend}, {31'd0, m_irq});
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic idle(input int n);
    sel = 1'b0; we = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd(input logic [1:0] a);
    sel = 1'b1; we = 1'b0; addr = a;
    tick();
    sel = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; data_in = d;
    tick();
    sel = 1'b0; we = 1'b0;
  endtask

  initial begin
    int h2, h3;
    logic [4:0] pat;
    rst = 1'b0; btn2 = 1'b1; btn3 = 1'b1; sw = 8'hFF;
    sel = 1'b1; we = 1'b1; addr = 2'd0; data_in = 32'hFFFF_FFFF;
    @(posedge clk);
    m_step();
    #1;

    // reset with everything high
    for (int a = 0; a < 3; a++) begin
      addr = 2'(a);
      tick();
      chk("rst_read", obs, 32'd0);
      chk("rst_irq", {31'd0, obs_irq}, 32'd0);
    end
    rst = 1'b1;
    idle(5);
    rd(2'd0); chk("rst_lvl_late", obs, 32'd0);
    rd(2'd0); chk("rst_lvl_up", obs, 32'hF);
    rd(2'd0); chk("rst_evt_clr", obs, 32'h3);
    rd(2'd3); chk("cfg_const", obs, 32'(N));

    btn2 = 1'b0; btn3 = 1'b0; sw = 8'h00;
    idle(8);
    rd(2'd1);
    rd(2'd1); chk("sw_idle", obs, 32'h0);
    rd(2'd0); chk("release_no_evt", obs, 32'd0);

    // btn2 press latency and read-clear
    btn2 = 1'b1;
    idle(6);
    rd(2'd0); chk("b2_first", obs, 32'h5);
    rd(2'd0); chk("b2_second", obs, 32'h1);
    btn2 = 1'b0;
    idle(8);
    rd(2'd0); chk("b2_release", obs, 32'h0);

    // rise coincides with a read
    btn2 = 1'b1;
    idle(5);
    rd(2'd0); chk("b2_rise_rd_old", obs, 32'h0);
    rd(2'd0); chk("b2_rise_rd_kept", obs, 32'h5);

    // btn3 bounce
    pat = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      btn3 = pat[i];
      tick();
    end
    btn3 = 1'b1;
    idle(5);
    rd(2'd0); chk("b3_early", obs & 32'h8, 32'h0);
    rd(2'd0); chk("b3_set", obs & 32'h8, 32'h8);
    btn2 = 1'b0; btn3 = 1'b0;
    idle(8);
    rd(2'd0); chk("b3_release", obs, 32'h0);

    // write-1-to-clear and irq lag
    btn2 = 1'b1; btn3 = 1'b1;
    idle(7);
    wr(2'd2, 32'h2); chk("w1c_irq_pre", {31'd0, obs_irq}, 32'd1);
    idle(1); chk("w1c_irq_hold1", {31'd0, obs_irq}, 32'd1);
    idle(1); chk("w1c_irq_hold2", {31'd0, obs_irq}, 32'd1);
    wr(2'd2, 32'h1);
    idle(1); chk("w1c_irq_lag", {31'd0, obs_irq}, 32'd1);
    idle(1); chk("w1c_irq_clr", {31'd0, obs_irq}, 32'd0);
    rd(2'd0); chk("w1c_levels", obs, 32'h3);
    wr(2'd1, 32'hFFFF_FFFF); wr(2'd0, 32'hF); wr(2'd3, 32'h0);
    rd(2'd3); chk("cfg_after_wr", obs, 32'(N));
    btn2 = 1'b0; btn3 = 1'b0;
    idle(8);
    rd(2'd0); chk("both_release", obs, 32'h0);

    // switch change flag
    sw = 8'hA5;
    idle(3);
    rd(2'd1); chk("sw_chg_set", obs, 32'h1A5);
    rd(2'd1); chk("sw_chg_clr", obs, 32'h0A5);

    // reset in the middle of a debounce
    btn2 = 1'b1;
    idle(4);
    rst = 1'b0; btn2 = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(8);
    rd(2'd0); chk("rst_abort", obs, 32'h0);
    rd(2'd1); chk("rst_abort_sw", obs & 32'h1FF, 32'h1A5);

    // random traffic against the model
    h2 = 1; h3 = 1;
    for (int c = 0; c < 3000; c++) begin
      h2--; h3--;
      if (h2 == 0) begin btn2 = ~btn2; h2 = $urandom_range(1, 7); end
      if (h3 == 0) begin btn3 = ~btn3; h3 = $urandom_range(1, 7); end
      if ($urandom_range(0, 15) == 0) sw = 8'($urandom);
      sel     = ($urandom_range(0, 3) == 0);
      we      = 1'($urandom_range(0, 1));
      addr    = 2'($urandom_range(0, 3));
      data_in = $urandom;
      rst     = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
